// File: rtl/ram_bus_arbiter.sv
// Two-master arbiter for the single-port data RAM: one registered grant per
// transaction, round-robin or fixed priority with an m1 starvation guard.
module ram_bus_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 32,
  parameter int PRIORITY_MODE = 0,
  parameter int STARVE_LIMIT  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wd,
  input  logic [DATA_WIDTH-1:0] mem_rd,
  output logic                  busy,
  output logic                  owner
);

  // Handshake: a master holds req/we/addr/wdata until its one-cycle gnt;
  // a read returns rvalid plus rdata on the cycle after gnt.

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  localparam logic [7:0] STARVE_LIM8 = 8'(STARVE_LIMIT);

  state_t                state_q, state_d;
  logic                  sel_q, sel_d;
  logic                  owner_q, owner_d;
  logic                  winner;
  logic [7:0]            starve_q, starve_d;
  logic                  m0_rvalid_q, m1_rvalid_q;
  logic [DATA_WIDTH-1:0] m0_rdata_q, m1_rdata_q;
  logic                  access;

  assign access = (state_q == ACCESS);

  always_comb begin
    winner = 1'b0;
    if (PRIORITY_MODE == 0) begin
      if (m0_req && m1_req) winner = ~owner_q;
      else                  winner = m1_req;
    end else begin
      // Starvation guard overrides m0's static priority.
      if (m1_req && (starve_q >= STARVE_LIM8)) winner = 1'b1;
      else                                     winner = ~m0_req;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    owner_d = owner_q;
    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          state_d = ACCESS;
          sel_d   = winner;
          owner_d = winner;
        end
      end
      ACCESS:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m0_gnt   = access && !sel_q;
    m1_gnt   = access &&  sel_q;
    busy     = access;
    mem_addr = '0;
    mem_we   = 1'b0;
    mem_wd   = '0;
    if (access) begin
      mem_addr = sel_q ? m1_addr  : m0_addr;
      mem_we   = sel_q ? m1_we    : m0_we;
      mem_wd   = sel_q ? m1_wdata : m0_wdata;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (PRIORITY_MODE == 0 || !m1_req || m1_gnt) starve_d = '0;
    else if (starve_q != 8'hFF)                  starve_d = starve_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      sel_q    <= 1'b0;
      owner_q  <= 1'b1;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      owner_q  <= owner_d;
      starve_q <= starve_d;
    end
  end

  // Synchronous RAM: read data appears on mem_rd the cycle after ACCESS.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
    end else begin
      m0_rvalid_q <= m0_gnt && !m0_we;
      m1_rvalid_q <= m1_gnt && !m1_we;
      if (m0_rvalid_q) m0_rdata_q <= mem_rd;
      if (m1_rvalid_q) m1_rdata_q <= mem_rd;
    end
  end

  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;
  assign m0_rdata  = m0_rvalid_q ? mem_rd : m0_rdata_q;
  assign m1_rdata  = m1_rvalid_q ? mem_rd : m1_rdata_q;
  assign owner     = owner_q;

endmodule

// File: doc/ram_bus_arbiter.md
Name: ram_bus_arbiter

Overview:
- Shares the single-port data RAM between two bus masters.
  - m0: the riscv_core load/store path.
  - m1: a secondary master, such as a program loader or debug port.
- Sits between the masters and the RAM-side address/data bus that feeds peripherals_control_unit.
- One transaction per grant: request/grant handshake and registered arbitration.
- Selectable round-robin or fixed-priority policy, with a starvation guard in fixed-priority mode.

Parameters:
- DATA_WIDTH, 32, data bus width.
- ADDR_WIDTH, 32, address bus width.
- PRIORITY_MODE, 0. 0 = round-robin; 1 = fixed priority with m0 highest.
- STARVE_LIMIT, 8. In fixed mode, the number of consecutive waiting cycles after which m1 is forced to win. Range 1..255.

Ports:
- clk  in  1  system clock (the heartbeat-divided core clock at top level).
- rst  in  1  asynchronous, active-high reset.
- m0_req  in  1  m0 access request.
- m0_we  in  1  m0 write enable (1 = write, 0 = read).
- m0_addr  in  ADDR_WIDTH  m0 address.
- m0_wdata  in  DATA_WIDTH  m0 write data.
- m0_gnt  out  1  one-cycle pulse; m0 access is on the RAM bus this cycle.
- m0_rvalid  out  1  one-cycle pulse; m0 read data is valid.
- m0_rdata  out  DATA_WIDTH  m0 read data.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as the m0 signals, for m1.
- mem_addr  out  ADDR_WIDTH  address to the RAM bus.
- mem_we  out  1  write enable to the RAM bus.
- mem_wd  out  DATA_WIDTH  write data to the RAM bus.
- mem_rd  in  DATA_WIDTH  RAM read data; synchronous RAM, valid the cycle after the address is presented.
- busy  out  1  high while in ACCESS.
- owner  out  1  last-granted master (0 = m0, 1 = m1).

Behaviour:
- Reset values (asynchronous): FSM = IDLE; all gnt and rvalid = 0; mem_addr, mem_we, mem_wd = 0; rdata registers = 0; busy = 0; owner = 1 (so m0 wins the first tie); starve_cnt = 0.
- FSM states: IDLE and ACCESS.
  - IDLE: if any req is high at a clk edge, latch the winner into sel and go to ACCESS. Otherwise stay in IDLE.
  - ACCESS: lasts exactly 1 cycle, then returns to IDLE unconditionally.
  - Throughput: at most one transaction per 2 cycles.
- ACCESS cycle outputs:
  - mem_addr, mem_we and mem_wd are muxed combinationally from the selected master's inputs.
  - The selected master's gnt = 1.
  - busy = 1.
- Outside ACCESS: mem_we = 0, mem_addr = 0, mem_wd = 0.
- Read return:
  - If the ACCESS was a read, then on the following cycle the selected master's rvalid = 1 and its rdata = mem_rd captured at that cycle.
  - The other master's rvalid stays 0.
  - rdata holds its value until the next read for the same master.
  - A write produces no rvalid.
- Master obligations:
  - Hold req, we, addr and wdata stable from req assertion through the gnt cycle.
  - Deassert req, or present a new request, in the cycle after gnt.
  - A req sampled in the same edge as gnt falling is treated as a new request.
- Round-robin winner (PRIORITY_MODE = 0):
  - Only one req high: that master wins.
  - Both req high: the master not equal to owner wins.
  - owner updates to the winner on entry to ACCESS.
- Fixed-priority winner (PRIORITY_MODE = 1):
  - m0 wins whenever m0_req = 1, unless starve_cnt >= STARVE_LIMIT, in which case m1 wins.
- starve_cnt (8-bit, saturating):
  - Increments each cycle in which m1_req = 1 and m1 is not granted.
  - Clears on an m1 grant or when m1_req = 0.
  - Held at 0 when PRIORITY_MODE = 0.
- A request that deasserts before it is granted is dropped with no side effects.
- Reset mid-ACCESS: gnt and mem_we drop asynchronously, the transaction is aborted and no rvalid is issued. The master must reissue the request.

Test Plan:
1. Reset: rst = 1 for 3 cycles, then release -> busy = 0, mem_we = 0, both gnt and rvalid = 0, owner = 1.
2. m0 write/read: m0 writes addr 0x10, data 0xDEADBEEF -> m0_gnt pulses 1 cycle after req with mem_we = 1, mem_addr = 0x10. A following m0 read of 0x10 -> m0_rvalid one cycle after gnt with m0_rdata = 0xDEADBEEF.
3. Round-robin contention: both masters hold req continuously for 8 grants -> grants alternate m0, m1, m0, m1 with a 2-cycle spacing; m1_rvalid never asserts for an m0 read.
4. Fixed-priority starvation: PRIORITY_MODE = 1, STARVE_LIMIT = 4, m0_req held high and m1_req held high -> m1 is granted after starve_cnt reaches 4, then starve_cnt clears and m0 resumes.
5. Request withdrawal: m1_req pulses for 1 cycle while m0 is in ACCESS -> m1 is never granted and mem_* shows only m0 traffic.
6. Reset mid-ACCESS: assert rst during an m1 write gnt cycle -> mem_we and m1_gnt fall immediately, no rvalid, FSM = IDLE after release.
